pipe_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline. It drives stall and flush enables into the F, D, E, M and W pipeline registers, including the M->W control register, and produces forwarding selects for E and D. It holds the pipeline for multi-cycle data-memory accesses with a small FSM and wait counter. It also keeps a saturating stall-cycle counter for debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and FSM state type for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

   localparam logic [1:0] MR_ALU  = 2'b00;
   localparam logic [1:0] MR_LOAD = 2'b01;
   localparam logic [1:0] MR_LINK = 2'b10;

   localparam logic [1:0] FW_RF = 2'b00;
   localparam logic [1:0] FW_W  = 2'b01;
   localparam logic [1:0] FW_M  = 2'b10;

   typedef enum logic {
      RUN     = 1'b0,
      MEMWAIT = 1'b1
   } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational forwarding selects for the E-stage operands and the D-stage compare.
module fwd_unit
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REGW = 5
) (
   input  logic [REGW-1:0] rsD,
   input  logic [REGW-1:0] rtD,
   input  logic [REGW-1:0] rsE,
   input  logic [REGW-1:0] rtE,
   input  logic [REGW-1:0] writeregM,
   input  logic            regwrM,
   input  logic [1:0]      memregM,
   input  logic [REGW-1:0] writeregW,
   input  logic            regwrW,
   output logic [1:0]      forwardAE,
   output logic [1:0]      forwardBE,
   output logic            forwardAD,
   output logic            forwardBD
);

   logic mValid;
   logic wValid;

   // r0 is hardwired zero, so a write to it is never a producer.
   assign mValid = regwrM && (writeregM != '0);
   assign wValid = regwrW && (writeregW != '0);

   always_comb begin
      forwardAE = FW_RF;
      forwardBE = FW_RF;
      if (mValid && (writeregM == rsE))      forwardAE = FW_M;
      else if (wValid && (writeregW == rsE)) forwardAE = FW_W;
      if (mValid && (writeregM == rtE))      forwardBE = FW_M;
      else if (wValid && (writeregW == rtE)) forwardBE = FW_W;
   end

   // Load data is not available in M yet, so only ALU/link results feed the D compare.
   assign forwardAD = mValid && (memregM != MR_LOAD) && (writeregM == rsD);
   assign forwardBD = mValid && (memregM != MR_LOAD) && (writeregM == rtD);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forwarding and multi-cycle memory wait.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int REGW    = 5,
   parameter int CNTW    = 16
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic [REGW-1:0] rsD,
   input  logic [REGW-1:0] rtD,
   input  logic            branchD,
   input  logic            branchtakenD,
   input  logic [REGW-1:0] rsE,
   input  logic [REGW-1:0] rtE,
   input  logic [REGW-1:0] writeregE,
   input  logic            regwrE,
   input  logic [1:0]      memregE,
   input  logic [REGW-1:0] writeregM,
   input  logic            regwrM,
   input  logic [1:0]      memregM,
   input  logic            memaccM,
   input  logic [REGW-1:0] writeregW,
   input  logic            regwrW,
   output logic            stallF,
   output logic            stallD,
   output logic            stallE,
   output logic            stallM,
   output logic            flushD,
   output logic            flushE,
   output logic            flushW,
   output logic [1:0]      forwardAE,
   output logic [1:0]      forwardBE,
   output logic            forwardAD,
   output logic            forwardBD,
   output logic [CNTW-1:0] stallcnt,
   output state_t          dbgState
);

   localparam bit         MEM_EN = (MEM_LAT > 0);
   localparam logic [3:0] WSTART = MEM_EN ? 4'(MEM_LAT - 1) : 4'd0;

   state_t     stateQ, stateNext;
   logic [3:0] wcnt, wcntNext;
   logic       memStall;
   logic       eHitsD, mHitsD, luHaz, brHaz;
   logic [1:0] fwdAE, fwdBE;
   logic       fwdAD, fwdBD;

   fwd_unit #(.REGW(REGW)) u_fwd (
      .rsD       (rsD),
      .rtD       (rtD),
      .rsE       (rsE),
      .rtE       (rtE),
      .writeregM (writeregM),
      .regwrM    (regwrM),
      .memregM   (memregM),
      .writeregW (writeregW),
      .regwrW    (regwrW),
      .forwardAE (fwdAE),
      .forwardBE (fwdBE),
      .forwardAD (fwdAD),
      .forwardBD (fwdBD)
   );

   assign forwardAE = RSTn ? fwdAE : FW_RF;
   assign forwardBE = RSTn ? fwdBE : FW_RF;
   assign forwardAD = RSTn && fwdAD;
   assign forwardBD = RSTn && fwdBD;

   assign eHitsD = (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
   assign mHitsD = (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));
   assign luHaz  = (memregE == MR_LOAD) && regwrE && eHitsD;
   assign brHaz  = branchD && ((regwrE && eHitsD) || ((memregM == MR_LOAD) && mHitsD));

   // The release cycle (MEMWAIT, wcnt==0) ignores memaccM so the finished access can leave M.
   always_comb begin
      stateNext = stateQ;
      wcntNext  = wcnt;
      memStall  = 1'b0;
      case (stateQ)
         RUN: begin
            if (memaccM && MEM_EN) begin
               memStall  = 1'b1;
               stateNext = MEMWAIT;
               wcntNext  = WSTART;
            end
         end
         MEMWAIT: begin
            if (wcnt != 4'd0) begin
               memStall = 1'b1;
               wcntNext = wcnt - 4'd1;
            end else begin
               stateNext = RUN;
            end
         end
         default: stateNext = RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         stateQ <= RUN;
         wcnt   <= 4'd0;
      end else begin
         stateQ <= stateNext;
         wcnt   <= wcntNext;
      end
   end

   // Frozen stages are never flushed; only the W input gets a bubble during a memory wait.
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushW = 1'b0;
      if (!RSTn) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushW = 1'b1;
      end else if (memStall) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
         flushW = 1'b1;
      end else if (luHaz || brHaz) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end else if (branchtakenD) begin
         flushD = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         stallcnt <= '0;
      end else if (stallF && (stallcnt != {CNTW{1'b1}})) begin
         stallcnt <= stallcnt + CNTW'(1);
      end
   end

   assign dbgState = stateQ;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven and sequence checks for pipe_hazard_ctrl with an expected-output queue.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int MEM_LAT = 2;
  localparam int REGW    = 5;
  localparam int CNTW    = 16;
  localparam int W       = 14;  // {state, stallF,D,E,M, flushD,E,W, fAE, fBE, fAD, fBD}

  logic            CLK = 1'b0;
  logic            RSTn;
  logic [REGW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic            branchD, branchtakenD, regwrE, regwrM, memaccM, regwrW;
  logic [1:0]      memregE, memregM;
  logic            stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [1:0]      forwardAE, forwardBE;
  logic            forwardAD, forwardBD;
  logic [CNTW-1:0] stallcnt;
  state_t          dbgState;

  pipe_hazard_ctrl #(.MEM_LAT(MEM_LAT), .REGW(REGW), .CNTW(CNTW)) dut (
    .CLK(CLK), .RSTn(RSTn), .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .branchtakenD(branchtakenD), .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
    .regwrE(regwrE), .memregE(memregE), .writeregM(writeregM), .regwrM(regwrM),
    .memregM(memregM), .memaccM(memaccM), .writeregW(writeregW), .regwrW(regwrW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW), .forwardAE(forwardAE),
    .forwardBE(forwardBE), .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallcnt(stallcnt), .dbgState(dbgState)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rstn;
    logic [4:0] rsd, rtd;
    logic       bd, bt;
    logic [4:0] rse, rte, wre;
    logic       rwe;
    logic [1:0] mre;
    logic [4:0] wrm;
    logic       rwm;
    logic [1:0] mrm;
    logic       acc;
    logic [4:0] wrw;
    logic       rww;
    logic [W-1:0] e;
  } vec_t;

  logic [W-1:0]    exp_q[$];
  logic [CNTW-1:0] expCnt;
  logic            pendInc;
  int              total = 0;
  int              bad = 0;
  vec_t            tbl[16];
  vec_t            v;

  function automatic logic [W-1:0] ex(input logic st, input logic [3:0] stl, input logic [2:0] fl,
                                      input logic [1:0] ae, input logic [1:0] be,
                                      input logic ad, input logic bd);
    return {st, stl, fl, ae, be, ad, bd};
  endfunction

  function automatic vec_t mk(input logic [4:0] rsd, input logic [4:0] rtd, input logic bd,
                              input logic bt, input logic [4:0] rse, input logic [4:0] rte,
                              input logic [4:0] wre, input logic rwe, input logic [1:0] mre,
                              input logic [4:0] wrm, input logic rwm, input logic [1:0] mrm,
                              input logic acc, input logic [4:0] wrw, input logic rww,
                              input logic [W-1:0] e);
    vec_t r;
    r.rstn = 1'b1; r.rsd = rsd; r.rtd = rtd; r.bd = bd; r.bt = bt;
    r.rse = rse; r.rte = rte; r.wre = wre; r.rwe = rwe; r.mre = mre;
    r.wrm = wrm; r.rwm = rwm; r.mrm = mrm; r.acc = acc; r.wrw = wrw; r.rww = rww;
    r.e = e;
    return r;
  endfunction

  // driver: apply one cycle of inputs, queue the expected outputs, compare at the falling edge
  task automatic drive(input vec_t dv, input string tag);
    logic [W-1:0] got, want;
    @(posedge CLK);
    #1;
    if (pendInc && (expCnt != {CNTW{1'b1}})) expCnt = expCnt + 1'b1;
    pendInc = dv.e[12];
    if (!dv.rstn) begin
      expCnt  = '0;
      pendInc = 1'b0;
    end
    RSTn = dv.rstn; rsD = dv.rsd; rtD = dv.rtd; branchD = dv.bd; branchtakenD = dv.bt;
    rsE = dv.rse; rtE = dv.rte; writeregE = dv.wre; regwrE = dv.rwe; memregE = dv.mre;
    writeregM = dv.wrm; regwrM = dv.rwm; memregM = dv.mrm; memaccM = dv.acc;
    writeregW = dv.wrw; regwrW = dv.rww;
    exp_q.push_back(dv.e);
    @(negedge CLK);
    got  = {dbgState, stallF, stallD, stallE, stallM, flushD, flushE, flushW,
            forwardAE, forwardBE, forwardAD, forwardBD};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", tag, got, want);
    end
  endtask

  // stallcnt reflects every cycle before the one currently applied
  task automatic check_cnt(input string tag);
    total++;
    if (stallcnt !== expCnt) begin
      bad++;
      $display("FAIL %s: stallcnt=%0d want=%0d", tag, stallcnt, expCnt);
    end
  endtask

  initial begin
    RSTn = 1'b0; rsD = '0; rtD = '0; branchD = 0; branchtakenD = 0; rsE = '0; rtE = '0;
    writeregE = '0; regwrE = 0; memregE = '0; writeregM = '0; regwrM = 0; memregM = '0;
    memaccM = 0; writeregW = '0; regwrW = 0;
    expCnt = '0; pendInc = 1'b0;

    tbl[0]  = mk(0,0,0,0, 0,0,0,0,MR_ALU,  0,0,MR_ALU,  0, 0,0, ex(0,4'b0000,3'b000,FW_RF,FW_RF,0,0));
    tbl[1]  = mk(0,0,0,0, 3,0,0,0,MR_ALU,  3,1,MR_ALU,  0, 0,0, ex(0,4'b0000,3'b000,FW_M, FW_RF,0,0));
    tbl[2]  = mk(0,0,0,0, 3,0,0,0,MR_ALU,  0,0,MR_ALU,  0, 3,1, ex(0,4'b0000,3'b000,FW_W, FW_RF,0,0));
    tbl[3]  = mk(0,0,0,0, 7,7,0,0,MR_ALU,  7,1,MR_ALU,  0, 7,1, ex(0,4'b0000,3'b000,FW_M, FW_M, 0,0));
    tbl[4]  = mk(0,0,0,0, 0,0,0,0,MR_ALU,  0,1,MR_ALU,  0, 0,1, ex(0,4'b0000,3'b000,FW_RF,FW_RF,0,0));
    tbl[5]  = mk(0,0,0,0, 0,9,0,0,MR_ALU,  0,0,MR_ALU,  0, 9,1, ex(0,4'b0000,3'b000,FW_RF,FW_W, 0,0));
    tbl[6]  = mk(0,0,0,0, 3,0,0,0,MR_ALU,  3,0,MR_ALU,  0, 3,1, ex(0,4'b0000,3'b000,FW_W, FW_RF,0,0));
    tbl[7]  = mk(0,4,0,0, 0,0,4,1,MR_LOAD, 0,0,MR_ALU,  0, 0,0, ex(0,4'b1100,3'b010,FW_RF,FW_RF,0,0));
    tbl[8]  = mk(0,4,0,0, 0,0,4,0,MR_LOAD, 0,0,MR_ALU,  0, 0,0, ex(0,4'b0000,3'b000,FW_RF,FW_RF,0,0));
    tbl[9]  = mk(0,0,0,0, 0,0,0,1,MR_LOAD, 0,0,MR_ALU,  0, 0,0, ex(0,4'b0000,3'b000,FW_RF,FW_RF,0,0));
    tbl[10] = mk(1,2,1,1, 0,0,0,0,MR_ALU,  0,0,MR_ALU,  0, 0,0, ex(0,4'b0000,3'b100,FW_RF,FW_RF,0,0));
    tbl[11] = mk(5,0,1,1, 0,0,5,1,MR_ALU,  0,0,MR_ALU,  0, 0,0, ex(0,4'b1100,3'b010,FW_RF,FW_RF,0,0));
    tbl[12] = mk(0,6,1,0, 0,0,0,0,MR_ALU,  6,1,MR_LOAD, 0, 0,0, ex(0,4'b1100,3'b010,FW_RF,FW_RF,0,0));
    tbl[13] = mk(5,0,1,1, 0,0,0,0,MR_ALU,  5,1,MR_ALU,  0, 0,0, ex(0,4'b0000,3'b100,FW_RF,FW_RF,1,0));
    tbl[14] = mk(0,8,0,0, 0,0,0,0,MR_ALU,  8,1,MR_LINK, 0, 0,0, ex(0,4'b0000,3'b000,FW_RF,FW_RF,0,1));
    tbl[15] = mk(1,2,1,0, 0,0,0,0,MR_ALU,  0,0,MR_ALU,  0, 0,0, ex(0,4'b0000,3'b000,FW_RF,FW_RF,0,0));

    // reset state
    v = mk(0,0,0,0, 3,0,0,0,MR_ALU, 3,1,MR_ALU, 0, 0,0, ex(0,4'b0000,3'b111,FW_RF,FW_RF,0,0));
    v.rstn = 1'b0;
    drive(v, "reset0");
    drive(v, "reset1");
    check_cnt("reset_cnt");

    // add r3 flows E -> M -> W while the consumer moves D -> E
    drive(mk(3,0,0,0, 0,0,3,1,MR_ALU, 0,0,MR_ALU, 0, 0,0, ex(0,4'b0000,3'b000,FW_RF,FW_RF,0,0)), "add_e");
    drive(mk(0,0,0,0, 3,0,0,0,MR_ALU, 3,1,MR_ALU, 0, 0,0, ex(0,4'b0000,3'b000,FW_M, FW_RF,0,0)), "add_m");
    drive(mk(0,0,0,0, 3,0,0,0,MR_ALU, 0,0,MR_ALU, 0, 3,1, ex(0,4'b0000,3'b000,FW_W, FW_RF,0,0)), "add_w");

    // load-use: one bubble, then W forward
    drive(mk(0,4,0,0, 0,0,4,1,MR_LOAD, 0,0,MR_ALU,  0, 0,0, ex(0,4'b1100,3'b010,FW_RF,FW_RF,0,0)), "lu_stall");
    drive(mk(0,4,0,0, 0,0,0,0,MR_ALU,  4,1,MR_LOAD, 0, 0,0, ex(0,4'b0000,3'b000,FW_RF,FW_RF,0,0)), "lu_bubble");
    check_cnt("lu_cnt");
    drive(mk(0,0,0,0, 0,4,0,0,MR_ALU,  0,0,MR_ALU,  0, 4,1, ex(0,4'b0000,3'b000,FW_RF,FW_W, 0,0)), "lu_fwd");

    // branch on an E producer: stall first, then taken flush with D forward
    drive(mk(5,0,1,1, 0,0,5,1,MR_ALU, 0,0,MR_ALU, 0, 0,0, ex(0,4'b1100,3'b010,FW_RF,FW_RF,0,0)), "br_stall");
    drive(mk(5,0,1,1, 0,0,0,0,MR_ALU, 5,1,MR_ALU, 0, 0,0, ex(0,4'b0000,3'b100,FW_RF,FW_RF,1,0)), "br_taken");

    for (int i = 0; i < 16; i++) drive(tbl[i], $sformatf("vec%0d", i));
    check_cnt("table_cnt");

    // two back-to-back accesses, memstall outranks a load-use in the same cycle
    drive(mk(0,0,0,0, 0,0,0,0,MR_ALU,  0,0,MR_ALU, 1, 0,0, ex(0,4'b1111,3'b001,FW_RF,FW_RF,0,0)), "mem1_a");
    drive(mk(0,4,0,0, 0,0,4,1,MR_LOAD, 0,0,MR_ALU, 1, 0,0, ex(1,4'b1111,3'b001,FW_RF,FW_RF,0,0)), "mem1_b");
    drive(mk(0,0,0,0, 0,0,0,0,MR_ALU,  0,0,MR_ALU, 1, 0,0, ex(1,4'b0000,3'b000,FW_RF,FW_RF,0,0)), "mem1_rel");
    drive(mk(0,0,0,0, 0,0,0,0,MR_ALU,  0,0,MR_ALU, 1, 0,0, ex(0,4'b1111,3'b001,FW_RF,FW_RF,0,0)), "mem2_a");
    drive(mk(0,0,0,0, 0,0,0,0,MR_ALU,  0,0,MR_ALU, 1, 0,0, ex(1,4'b1111,3'b001,FW_RF,FW_RF,0,0)), "mem2_b");
    drive(mk(0,0,0,0, 0,0,0,0,MR_ALU,  0,0,MR_ALU, 1, 0,0, ex(1,4'b0000,3'b000,FW_RF,FW_RF,0,0)), "mem2_rel");
    drive(mk(0,0,0,0, 0,0,0,0,MR_ALU,  0,0,MR_ALU, 0, 0,0, ex(0,4'b0000,3'b000,FW_RF,FW_RF,0,0)), "mem_idle");
    check_cnt("mem_cnt");

    // reset dropped while waiting on memory
    drive(mk(0,0,0,0, 0,0,0,0,MR_ALU, 0,0,MR_ALU, 1, 0,0, ex(0,4'b1111,3'b001,FW_RF,FW_RF,0,0)), "rst_mem_a");
    v = mk(0,0,0,0, 3,0,0,0,MR_ALU, 3,1,MR_ALU, 1, 0,0, ex(0,4'b0000,3'b111,FW_RF,FW_RF,0,0));
    v.rstn = 1'b0;
    drive(v, "rst_mid_wait");
    check_cnt("rst_mid_cnt");
    drive(mk(0,0,0,0, 0,0,0,0,MR_ALU, 0,0,MR_ALU, 0, 0,0, ex(0,4'b0000,3'b000,FW_RF,FW_RF,0,0)), "rst_release");
    check_cnt("rst_release_cnt");

    // saturation of the stall counter
    v = mk(0,4,0,0, 0,0,4,1,MR_LOAD, 0,0,MR_ALU, 0, 0,0, ex(0,4'b1100,3'b010,FW_RF,FW_RF,0,0));
    for (int i = 0; i < (1 << CNTW) + 5; i++) drive(v, "sat_stall");
    drive(mk(0,0,0,0, 0,0,0,0,MR_ALU, 0,0,MR_ALU, 0, 0,0, ex(0,4'b0000,3'b000,FW_RF,FW_RF,0,0)), "sat_idle");
    check_cnt("sat_cnt");
    total++;
    if (stallcnt !== {CNTW{1'b1}}) begin
      bad++;
      $display("FAIL sat_allones: stallcnt=%0h want=%0h", stallcnt, {CNTW{1'b1}});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
